// File: rtl/core_mem_arbiter.sv
// Merges the instruction-fetch and load/store ports onto one shared valid/ready
// memory bus. One outstanding transaction at a time; ties resolved by priority or round-robin.
module core_mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DMEM_PRIORITY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    imem_valid_i,
  output logic                    imem_ready_o,
  input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
  input  logic [DATA_WIDTH-1:0]   imem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] imem_we_i,
  output logic [DATA_WIDTH-1:0]   imem_rdata_o,
  input  logic                    dmem_valid_i,
  output logic                    dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] dmem_we_i,
  output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam int BW = DATA_WIDTH / 8;

  // state  | meaning
  // S_IDLE | no transaction, arbitrate on incoming valids
  // S_BUS  | request held on the shared bus until mem_ready_i
  // S_RESP | one-cycle ready pulse to the owner; valids ignored
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_owner, w_owner_nxt;
  logic                  r_last_grant, w_last_grant_nxt;
  logic                  r_mem_valid, w_mem_valid_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [BW-1:0]         r_mem_we, w_mem_we_nxt;
  logic                  r_imem_ready, w_imem_ready_nxt;
  logic                  r_dmem_ready, w_dmem_ready_nxt;
  logic [DATA_WIDTH-1:0] r_imem_rdata, w_imem_rdata_nxt;
  logic [DATA_WIDTH-1:0] r_dmem_rdata, w_dmem_rdata_nxt;
  logic                  w_grant_dmem;

  // owner / last_grant encoding: 0 = IMEM, 1 = DMEM
  always_comb begin
    if (imem_valid_i && dmem_valid_i)
      w_grant_dmem = (DMEM_PRIORITY != 0) ? 1'b1 : ~r_last_grant;
    else
      w_grant_dmem = dmem_valid_i;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_mem_valid_nxt  = r_mem_valid;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_mem_we_nxt     = r_mem_we;
    w_imem_ready_nxt = 1'b0;
    w_dmem_ready_nxt = 1'b0;
    w_imem_rdata_nxt = r_imem_rdata;
    w_dmem_rdata_nxt = r_dmem_rdata;
    case (r_state)
      S_IDLE: begin
        if (imem_valid_i || dmem_valid_i) begin
          w_owner_nxt      = w_grant_dmem;
          w_last_grant_nxt = w_grant_dmem;
          w_mem_valid_nxt  = 1'b1;
          w_mem_addr_nxt   = w_grant_dmem ? dmem_addr_i  : imem_addr_i;
          w_mem_wdata_nxt  = w_grant_dmem ? dmem_wdata_i : imem_wdata_i;
          w_mem_we_nxt     = w_grant_dmem ? dmem_we_i    : imem_we_i;
          w_state_nxt      = S_BUS;
        end
      end
      S_BUS: begin
        if (mem_ready_i) begin
          if (r_owner) begin
            w_dmem_rdata_nxt = mem_rdata_i;
            w_dmem_ready_nxt = 1'b1;
          end else begin
            w_imem_rdata_nxt = mem_rdata_i;
            w_imem_ready_nxt = 1'b1;
          end
          w_mem_valid_nxt = 1'b0;
          w_state_nxt     = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= '0;
      r_imem_ready <= 1'b0;
      r_dmem_ready <= 1'b0;
      r_imem_rdata <= '0;
      r_dmem_rdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_mem_valid  <= w_mem_valid_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_imem_ready <= w_imem_ready_nxt;
      r_dmem_ready <= w_dmem_ready_nxt;
      r_imem_rdata <= w_imem_rdata_nxt;
      r_dmem_rdata <= w_dmem_rdata_nxt;
    end
  end

  assign mem_valid_o  = r_mem_valid;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;
  assign mem_we_o     = r_mem_we;
  assign imem_ready_o = r_imem_ready;
  assign dmem_ready_o = r_dmem_ready;
  assign imem_rdata_o = r_imem_rdata;
  assign dmem_rdata_o = r_dmem_rdata;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios plus random traffic on a
// fixed-priority and a round-robin instance, checked against a transaction-level model.
module tb_core_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: DMEM_PRIORITY=1, index 1: DMEM_PRIORITY=0
  logic [1:0]    iv, dv, mr, irdy, drdy, mv;
  logic [AW-1:0] ia[2], da[2], ma[2];
  logic [DW-1:0] iw[2], dw[2], mrd[2], ird[2], drd[2], mw[2];
  logic [BW-1:0] ie[2], de[2], me[2];

  int n_vec = 0;
  int n_err = 0;

  core_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DMEM_PRIORITY(1)) u_dut_fp (
    .clk(clk), .rst(rst),
    .imem_valid_i(iv[0]), .imem_ready_o(irdy[0]), .imem_addr_i(ia[0]), .imem_wdata_i(iw[0]),
    .imem_we_i(ie[0]), .imem_rdata_o(ird[0]),
    .dmem_valid_i(dv[0]), .dmem_ready_o(drdy[0]), .dmem_addr_i(da[0]), .dmem_wdata_i(dw[0]),
    .dmem_we_i(de[0]), .dmem_rdata_o(drd[0]),
    .mem_valid_o(mv[0]), .mem_ready_i(mr[0]), .mem_addr_o(ma[0]), .mem_wdata_o(mw[0]),
    .mem_we_o(me[0]), .mem_rdata_i(mrd[0])
  );

  core_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DMEM_PRIORITY(0)) u_dut_rr (
    .clk(clk), .rst(rst),
    .imem_valid_i(iv[1]), .imem_ready_o(irdy[1]), .imem_addr_i(ia[1]), .imem_wdata_i(iw[1]),
    .imem_we_i(ie[1]), .imem_rdata_o(ird[1]),
    .dmem_valid_i(dv[1]), .dmem_ready_o(drdy[1]), .dmem_addr_i(da[1]), .dmem_wdata_i(dw[1]),
    .dmem_we_i(de[1]), .dmem_rdata_o(drd[1]),
    .mem_valid_o(mv[1]), .mem_ready_i(mr[1]), .mem_addr_o(ma[1]), .mem_wdata_o(mw[1]),
    .mem_we_o(me[1]), .mem_rdata_i(mrd[1])
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    iv = '0; dv = '0; mr = '0;
    for (int k = 0; k < 2; k++) begin
      ia[k] = '0; iw[k] = '0; ie[k] = '0;
      da[k] = '0; dw[k] = '0; de[k] = '0; mrd[k] = '0;
    end
  endtask

  task automatic check_zero(input int k, input string tag);
    check_val({tag, "_mv"},   mv[k],   0);
    check_val({tag, "_irdy"}, irdy[k], 0);
    check_val({tag, "_drdy"}, drdy[k], 0);
    check_val({tag, "_ma"},   ma[k],   0);
    check_val({tag, "_mw"},   mw[k],   0);
    check_val({tag, "_me"},   me[k],   0);
    check_val({tag, "_ird"},  ird[k],  0);
    check_val({tag, "_drd"},  drd[k],  0);
  endtask

  // reference model state for the random phase
  bit            act[2], own[2], lg[2], resp_prev[2];
  logic [AW-1:0] lat_a[2];
  logic [DW-1:0] lat_w[2], exp_rd[2], exp_ird[2], exp_drd[2];
  logic [BW-1:0] lat_e[2];
  bit            si, sd, resp_due, rise, g;

  task automatic new_ireq(input int k);
    iv[k] = 1'b1;
    ia[k] = $urandom & 32'hFFFF_FFFC;
    iw[k] = $urandom;
    ie[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
  endtask

  task automatic new_dreq(input int k);
    dv[k] = 1'b1;
    da[k] = $urandom;
    dw[k] = $urandom;
    de[k] = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #1;
    check_zero(0, "rst_fp");
    check_zero(1, "rst_rr");
    step();
    rst = 1'b0;

    // single fetch, zero wait states
    iv[0] = 1; ia[0] = 32'h100; mr[0] = 1; mrd[0] = 32'hDEAD_BEEF;
    step();
    check_val("sf_mv", mv[0], 1);
    check_val("sf_ma", ma[0], 32'h100);
    check_val("sf_irdy_early", irdy[0], 0);
    step();
    check_val("sf_irdy", irdy[0], 1);
    check_val("sf_ird", ird[0], 32'hDEAD_BEEF);
    check_val("sf_drdy", drdy[0], 0);
    check_val("sf_mv_drop", mv[0], 0);
    iv[0] = 0;
    step();
    check_val("sf_irdy_pulse", irdy[0], 0);
    check_val("sf_ird_hold", ird[0], 32'hDEAD_BEEF);
    mr[0] = 0;
    step();

    // tie with data-port priority: store wins, fetch follows three cycles later
    iv[0] = 1; ia[0] = 32'h200;
    dv[0] = 1; da[0] = 32'h8000; de[0] = 4'hF; dw[0] = 32'h1234_5678;
    mr[0] = 1; mrd[0] = 32'hA1;
    step();
    check_val("tie_ma_d", ma[0], 32'h8000);
    check_val("tie_me_d", me[0], 4'hF);
    check_val("tie_mw_d", mw[0], 32'h1234_5678);
    step();
    check_val("tie_drdy", drdy[0], 1);
    check_val("tie_irdy_no", irdy[0], 0);
    check_val("tie_drd", drd[0], 32'hA1);
    dv[0] = 0; mrd[0] = 32'hB2;
    step();
    check_val("tie_resp_mv", mv[0], 0);
    check_val("tie_resp_drdy", drdy[0], 0);
    step();
    check_val("tie_mv_i", mv[0], 1);
    check_val("tie_ma_i", ma[0], 32'h200);
    check_val("tie_me_i", me[0], 0);
    step();
    check_val("tie_irdy", irdy[0], 1);
    check_val("tie_ird", ird[0], 32'hB2);
    check_val("tie_drd_hold", drd[0], 32'hA1);
    iv[0] = 0; mr[0] = 0;
    step();

    // five wait states; master moves its address mid-wait
    iv[0] = 1; ia[0] = 32'h300; mrd[0] = 32'h77;
    step();
    check_val("ws_mv_c1", mv[0], 1);
    check_val("ws_ma_c1", ma[0], 32'h300);
    ia[0] = 32'h3FC;
    for (int j = 2; j <= 6; j++) begin
      step();
      check_val("ws_mv", mv[0], 1);
      check_val("ws_ma", ma[0], 32'h300);
      check_val("ws_irdy", irdy[0], 0);
      if (j == 6) mr[0] = 1;
    end
    step();
    check_val("ws_irdy_c7", irdy[0], 1);
    check_val("ws_ird", ird[0], 32'h77);
    iv[0] = 0; mr[0] = 0;
    step();
    check_val("ws_irdy_c8", irdy[0], 0);
    step();

    // reset while the bus transaction is pending
    iv[0] = 1; ia[0] = 32'h400;
    step();
    check_val("rb_mv", mv[0], 1);
    #2 rst = 1'b1;
    #1;
    check_zero(0, "rb_async");
    step();
    rst = 1'b0; iv[0] = 0; mr[0] = 1; mrd[0] = 32'h99;
    for (int j = 0; j < 4; j++) begin
      step();
      check_val("rb_no_irdy", irdy[0], 0);
      check_val("rb_no_mv", mv[0], 0);
    end
    iv[0] = 1; ia[0] = 32'h404; mrd[0] = 32'h55;
    step();
    check_val("rb_new_ma", ma[0], 32'h404);
    step();
    check_val("rb_new_irdy", irdy[0], 1);
    check_val("rb_new_ird", ird[0], 32'h55);
    iv[0] = 0; mr[0] = 0;
    step();

    // round-robin: four back-to-back ties alternate, starting with DMEM
    iv[1] = 1; ia[1] = 32'h10; dv[1] = 1; da[1] = 32'h20; mr[1] = 1; mrd[1] = 32'h5A;
    for (int n = 0; n < 4; n++) begin
      step();
      check_val("rr_ma", ma[1], (n % 2 == 0) ? 32'h20 : 32'h10);
      step();
      check_val("rr_drdy", drdy[1], (n % 2 == 0) ? 1 : 0);
      check_val("rr_irdy", irdy[1], (n % 2 == 0) ? 0 : 1);
      step();
    end
    clear_inputs();
    step();

    // random traffic on both instances from a fresh reset
    rst = 1'b1;
    step();
    check_zero(0, "rst2_fp");
    check_zero(1, "rst2_rr");
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; own[k] = 0; lg[k] = 0; resp_prev[k] = 0;
      exp_ird[k] = '0; exp_drd[k] = '0; exp_rd[k] = '0;
      lat_a[k] = '0; lat_w[k] = '0; lat_e[k] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        si = iv[k]; sd = dv[k];
        resp_due = act[k] && mr[k];
        rise = !act[k] && !resp_prev[k] && (si || sd);
        g = 0;
        if (rise) g = (si && sd) ? ((k == 0) ? 1'b1 : !lg[k]) : sd;
        check_val("rnd_mv", mv[k], (act[k] && !resp_due) || rise);
        check_val("rnd_irdy", irdy[k], resp_due && !own[k]);
        check_val("rnd_drdy", drdy[k], resp_due && own[k]);
        if (resp_due) begin
          if (own[k]) exp_drd[k] = exp_rd[k];
          else        exp_ird[k] = exp_rd[k];
          act[k] = 0;
        end
        check_val("rnd_ird", ird[k], exp_ird[k]);
        check_val("rnd_drd", drd[k], exp_drd[k]);
        if (rise) begin
          own[k] = g; lg[k] = g; act[k] = 1;
          lat_a[k] = g ? da[k] : ia[k];
          lat_w[k] = g ? dw[k] : iw[k];
          lat_e[k] = g ? de[k] : ie[k];
        end
        if (act[k]) begin
          check_val("rnd_ma", ma[k], lat_a[k]);
          check_val("rnd_mw", mw[k], lat_w[k]);
          check_val("rnd_me", me[k], lat_e[k]);
        end
        resp_prev[k] = resp_due;

        mr[k]  = ($urandom_range(0, 2) == 0);
        mrd[k] = $urandom;
        if (act[k]) exp_rd[k] = mrd[k];

        if (irdy[k]) iv[k] = 0;
        else if (iv[k] && act[k] && !own[k] && $urandom_range(0, 3) == 0) ia[k] = $urandom;
        if (!iv[k] && $urandom_range(0, 2) == 0) new_ireq(k);

        if (drdy[k]) dv[k] = 0;
        else if (dv[k] && act[k] && own[k] && $urandom_range(0, 3) == 0) da[k] = $urandom;
        if (!dv[k] && $urandom_range(0, 2) == 0) new_dreq(k);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
